// File: rtl/cp0_ext.sv
// cp0_ext: coprocessor-0 register file with external interrupt and exception capture.
// Optional timer (Count/Compare, pending bit on IP[15]) is compiled in by
// defining CP0_EXT_TIMER_EN; without it Count/Compare read 0 and ignore writes.
module cp0_ext #(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID_VAL  = 32'h5A5A5943
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           ra,
  output logic [31:0]          rdata,
  input  logic [4:0]           wa,
  input  logic [31:0]          wdata,
  input  logic                 we,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic                 exc,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          exc_pc,
  input  logic                 exc_bd,
  input  logic [31:0]          bad_vaddr,
  input  logic                 bad_vaddr_we,
  input  logic                 eret,
  output logic                 int_req,
  output logic [31:0]          epc_out
);

  localparam logic [4:0] R_BADVA = 5'd8;
  localparam logic [4:0] R_COUNT = 5'd9;
  localparam logic [4:0] R_CMP   = 5'd11;
  localparam logic [4:0] R_SR    = 5'd12;
  localparam logic [4:0] R_CAUSE = 5'd13;
  localparam logic [4:0] R_EPC   = 5'd14;
  localparam logic [4:0] R_PRID  = 5'd15;

  logic [31:0]          sr, epc, bad_va;
  logic                 cause_bd;
  logic [1:0]           ip_sw;
  logic [4:0]           code_q;
  logic [NUM_HWINT-1:0] hw_q;
  logic [7:0]           ip;
  logic                 int_acc;
  logic                 wr_ok;
  logic [31:0]          cause;

`ifdef CP0_EXT_TIMER_EN
  logic [31:0] count, compare;
  logic        timer_pend;
`endif

  // Assemble the pending-interrupt vector: soft bits, registered lines, timer.
  always_comb begin
    ip = '0;
    ip[1:0] = ip_sw;
    for (int i = 0; i < NUM_HWINT; i++) ip[2+i] = hw_q[i];
`ifdef CP0_EXT_TIMER_EN
    ip[7] = ip[7] | timer_pend;
`endif
  end

  assign int_acc = sr[0] & ~sr[1] & (|(sr[15:8] & ip));
  // Reset masks the request so nothing is flushed during the reset cycle.
  assign int_req = ~reset & (int_acc | exc);
  // An mtc0 loses to any trap or return in the same cycle.
  assign wr_ok   = we & ~int_req & ~eret;
  assign epc_out = epc;
  assign cause   = {cause_bd, 15'b0, ip, 1'b0, code_q, 2'b0};

  // mfc0 read mux.
  always_comb begin
    rdata = '0;
    case (ra)
      R_BADVA: rdata = bad_va;
`ifdef CP0_EXT_TIMER_EN
      R_COUNT: rdata = count;
      R_CMP:   rdata = compare;
`endif
      R_SR:    rdata = sr;
      R_CAUSE: rdata = cause;
      R_EPC:   rdata = epc;
      R_PRID:  rdata = PRID_VAL;
      default: rdata = '0;
    endcase
  end

  // Architectural state: trap entry beats eret, which beats mtc0.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr       <= 32'h0000FF11;
      epc      <= '0;
      bad_va   <= '0;
      cause_bd <= 1'b0;
      ip_sw    <= '0;
      code_q   <= '0;
      hw_q     <= '0;
    end else begin
      hw_q <= hwint;
      if (int_req) begin
        epc      <= exc_bd ? exc_pc - 32'd4 : exc_pc;
        cause_bd <= exc_bd;
        sr[1]    <= 1'b1;
        code_q   <= int_acc ? 5'd0 : exc_code;
        if (exc && !int_acc && bad_vaddr_we) bad_va <= bad_vaddr;
      end else if (eret) begin
        sr[1]    <= 1'b0;
        cause_bd <= 1'b0;
      end else if (we) begin
        case (wa)
          R_SR:    sr    <= wdata;
          R_CAUSE: ip_sw <= wdata[9:8];
          R_EPC:   epc   <= wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_EXT_TIMER_EN
  // Free-running counter with a sticky match flag; a Compare write clears
  // the flag and wins over a match seen in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      compare    <= 32'hFFFFFFFF;
      timer_pend <= 1'b0;
    end else begin
      count <= (wr_ok && wa == R_COUNT) ? wdata : count + 32'd1;
      if (wr_ok && wa == R_CMP) begin
        compare    <= wdata;
        timer_pend <= 1'b0;
      end else if (count == compare) begin
        timer_pend <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cp0_ext.sv
// Scoreboard bench for cp0_ext: a driver applies stimulus after each rising
// edge and queues the expected outputs from a register-level reference model;
// a monitor pops and compares on the falling edge.
module tb_cp0_ext;
  localparam int NHW = 6;
  localparam logic [31:0] PRID = 32'h5A5A5943;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] ra, wa, exc_code;
  logic [31:0] rdata, wdata, exc_pc, bad_vaddr, epc_out;
  logic we, exc, exc_bd, bad_vaddr_we, eret, int_req;
  logic [NHW-1:0] hwint;

  cp0_ext #(.NUM_HWINT(NHW), .PRID_VAL(PRID)) dut (
    .clk(clk), .reset(reset), .ra(ra), .rdata(rdata), .wa(wa), .wdata(wdata),
    .we(we), .hwint(hwint), .exc(exc), .exc_code(exc_code), .exc_pc(exc_pc),
    .exc_bd(exc_bd), .bad_vaddr(bad_vaddr), .bad_vaddr_we(bad_vaddr_we),
    .eret(eret), .int_req(int_req), .epc_out(epc_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst; logic [5:0] hw; logic ex; logic [4:0] ec; logic [31:0] pc;
    logic bd; logic [31:0] bv; logic bvwe; logic er; logic w; logic [4:0] wa;
    logic [31:0] wd; logic [4:0] ra;
  } stim_t;

  typedef struct { logic full; logic irq; logic [31:0] rd; logic [31:0] epc; } exp_t;

  exp_t q[$];
  int errors = 0, checks = 0;

  // Reference model: architectural registers as plain variables.
  logic [31:0] m_sr, m_epc, m_bva, m_cnt, m_cmp;
  logic m_bd, m_tp;
  logic [1:0] m_ipsw;
  logic [4:0] m_code;
  logic [5:0] m_hw;

  function automatic logic [7:0] m_ip();
    logic [7:0] v;
    v = {6'b0, m_ipsw};
    for (int i = 0; i < NHW; i++) if (m_hw[i]) v[2+i] = 1'b1;
`ifdef CP0_EXT_TIMER_EN
    if (m_tp) v[7] = 1'b1;
`endif
    return v;
  endfunction

  function automatic logic m_acc();
    return m_sr[0] && !m_sr[1] && ((m_sr[15:8] & m_ip()) != 8'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    case (r)
      5'd8:  return m_bva;
`ifdef CP0_EXT_TIMER_EN
      5'd9:  return m_cnt;
      5'd11: return m_cmp;
`endif
      5'd12: return m_sr;
      5'd13: return {m_bd, 15'b0, m_ip(), 1'b0, m_code, 2'b0};
      5'd14: return m_epc;
      5'd15: return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic stim_t idle(input logic [4:0] r);
    stim_t s;
    s = '{rst:0, hw:0, ex:0, ec:0, pc:32'h100, bd:0, bv:0, bvwe:0, er:0, w:0, wa:0, wd:0, ra:r};
    return s;
  endfunction

  // One cycle: drive, predict, queue, then advance the model.
  task automatic cyc(input stim_t s);
    exp_t e;
    logic acc, irq, wr;
    @(posedge clk); #1;
    reset = s.rst; hwint = s.hw[NHW-1:0]; exc = s.ex; exc_code = s.ec; exc_pc = s.pc;
    exc_bd = s.bd; bad_vaddr = s.bv; bad_vaddr_we = s.bvwe; eret = s.er;
    we = s.w; wa = s.wa; wdata = s.wd; ra = s.ra;
    if (s.rst) begin
      e = '{full:1'b0, irq:1'b0, rd:32'd0, epc:32'd0};
      q.push_back(e);
      m_sr = 32'h0000FF11; m_epc = 0; m_bva = 0; m_cnt = 0; m_cmp = 32'hFFFFFFFF;
      m_bd = 0; m_tp = 0; m_ipsw = 0; m_code = 0; m_hw = 0;
      return;
    end
    acc = m_acc();
    irq = acc | s.ex;
    e = '{full:1'b1, irq:irq, rd:m_read(s.ra), epc:m_epc};
    q.push_back(e);
    wr = s.w && !irq && !s.er;
`ifdef CP0_EXT_TIMER_EN
    if (wr && s.wa == 5'd11) m_tp = 1'b0;
    else if (m_cnt == m_cmp) m_tp = 1'b1;
    m_cnt = (wr && s.wa == 5'd9) ? s.wd : m_cnt + 1;
    if (wr && s.wa == 5'd11) m_cmp = s.wd;
`endif
    if (irq) begin
      m_epc = s.bd ? s.pc - 4 : s.pc;
      m_bd = s.bd; m_sr[1] = 1'b1;
      m_code = acc ? 5'd0 : s.ec;
      if (s.ex && !acc && s.bvwe) m_bva = s.bv;
    end else if (s.er) begin
      m_sr[1] = 1'b0; m_bd = 1'b0;
    end else if (wr) begin
      if (s.wa == 5'd12) m_sr = s.wd;
      if (s.wa == 5'd13) m_ipsw = s.wd[9:8];
      if (s.wa == 5'd14) m_epc = s.wd;
    end
    m_hw = s.hw & 6'((1 << NHW) - 1);
  endtask

  // Monitor: compare whatever the driver queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (int_req !== e.irq) begin
        errors++; $display("FAIL int_req got=%0b exp=%0b t=%0t", int_req, e.irq, $time);
      end
      if (e.full) begin
        checks++;
        if (rdata !== e.rd) begin
          errors++; $display("FAIL rdata ra=%0d got=%h exp=%h t=%0t", ra, rdata, e.rd, $time);
        end
        checks++;
        if (epc_out !== e.epc) begin
          errors++; $display("FAIL epc_out got=%h exp=%h t=%0t", epc_out, e.epc, $time);
        end
      end
    end
  end

  initial begin
    stim_t s;
    logic [4:0] regs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    reset = 1; hwint = 0; exc = 0; exc_code = 0; exc_pc = 0; exc_bd = 0;
    bad_vaddr = 0; bad_vaddr_we = 0; eret = 0; we = 0; wa = 0; wdata = 0; ra = 0;

    // Reset with a pending exception: int_req must stay low.
    s = idle(5'd12); s.rst = 1; s.ex = 1; cyc(s); cyc(s);
    // Reset contents.
    cyc(idle(5'd12)); cyc(idle(5'd13)); cyc(idle(5'd14)); cyc(idle(5'd15));

    // External interrupt on line 0.
    for (int i = 0; i < 4; i++) cyc(idle(5'd13));
    s = idle(5'd13); s.hw = 6'b000001; s.pc = 32'h3010; cyc(s);
    cyc(s); cyc(s); s.ra = 5'd14; cyc(s); s.ra = 5'd12; cyc(s);
    s = idle(5'd12); cyc(s); s.er = 1; cyc(s);

    // Exception in delay slot with BadVAddr capture.
    s = idle(5'd8); s.ex = 1; s.ec = 5'd4; s.bd = 1; s.pc = 32'h3008;
    s.bv = 32'h1001; s.bvwe = 1; cyc(s);
    cyc(idle(5'd8)); cyc(idle(5'd13)); cyc(idle(5'd14));
    s = idle(5'd13); s.er = 1; cyc(s);

    // Interrupt beats a simultaneous exception; eret afterwards.
    s = idle(5'd13); s.hw = 6'b000100; cyc(s);
    s.ex = 1; s.ec = 5'd10; s.pc = 32'h5000; s.bv = 32'hDEAD; s.bvwe = 1; cyc(s);
    s = idle(5'd13); s.er = 1; cyc(s);
    cyc(idle(5'd13)); cyc(idle(5'd8));

    // SR cleared: no interrupt; then mtc0 EPC alongside eret is dropped.
    s = idle(5'd12); s.w = 1; s.wa = 5'd12; s.wd = 32'h0; cyc(s);
    s = idle(5'd13); s.hw = 6'b000001; cyc(s); cyc(s); cyc(s);
    s = idle(5'd14); s.w = 1; s.wa = 5'd14; s.wd = 32'h4000; s.er = 1; cyc(s);
    cyc(idle(5'd14));
    // Writes to read-only and partially writable registers.
    s = idle(5'd15); s.w = 1; s.wa = 5'd15; s.wd = 32'h1234; cyc(s);
    s.wa = 5'd8; s.ra = 5'd8; cyc(s);
    s.wa = 5'd13; s.wd = 32'hFFFFFFFF; s.ra = 5'd13; cyc(s);
    cyc(idle(5'd13));

    // Reset arriving in the cycle an interrupt would be taken.
    s = idle(5'd12); s.rst = 1; cyc(s);
    s = idle(5'd13); s.hw = 6'b000010; cyc(s);
    s.rst = 1; cyc(s);
    cyc(idle(5'd13)); cyc(idle(5'd14));

`ifdef CP0_EXT_TIMER_EN
    // Timer: Compare=20, Count=0, match raises IP[15].
    s = idle(5'd11); s.w = 1; s.wa = 5'd11; s.wd = 32'd20; cyc(s);
    s = idle(5'd9); s.w = 1; s.wa = 5'd9; s.wd = 32'd0; cyc(s);
    for (int i = 0; i < 24; i++) cyc(idle(i[0] ? 5'd13 : 5'd9));
    s = idle(5'd13); s.er = 1; cyc(s);
    s = idle(5'd13); s.w = 1; s.wa = 5'd11; s.wd = 32'd500; cyc(s);
    cyc(idle(5'd13));
    s = idle(5'd9); s.w = 1; s.wa = 5'd9; s.wd = 32'hFFFFFFFE; cyc(s);
    cyc(idle(5'd9)); cyc(idle(5'd9)); cyc(idle(5'd9));
`endif

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      s = idle(regs[$urandom_range(0, 7)]);
      s.rst  = ($urandom_range(0, 99) == 0);
      s.hw   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      s.ex   = ($urandom_range(0, 7) == 0);
      s.ec   = 5'($urandom);
      s.pc   = $urandom & 32'hFFFFFFFC;
      s.bd   = 1'($urandom);
      s.bv   = $urandom;
      s.bvwe = 1'($urandom);
      s.er   = ($urandom_range(0, 5) == 0);
      s.w    = ($urandom_range(0, 3) == 0);
      s.wa   = regs[$urandom_range(0, 7)];
      s.wd   = $urandom;
      if (s.w && s.wa == 5'd12 && $urandom_range(0, 1) == 1) s.wd[15:0] = 16'hFF01;
      cyc(s);
    end

    // Drain with a bounded wait.
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++; checks++;
      $display("FAIL drain pending=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cp0_ext.md
CP0_EXT -- requirements
Module: cp0_ext

Interface
REQ-001 Parameter NUM_HWINT, default 6, number of external interrupt lines (legal 1..6).
REQ-002 Parameter PRID_VAL, default 32'h5A5A5943, read-only PrID contents.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ra  in  5  read register index (mfc0); rdata  out  32  combinational read data.
REQ-006 wa  in  5  write index; wdata  in  32  write data; we  in  1  mtc0 strobe.
REQ-007 hwint  in  NUM_HWINT  level-sensitive external interrupt lines.
REQ-008 exc  in  1  exception pending in the committing stage; exc_code  in  5  its code.
REQ-009 exc_pc  in  32  PC of the committing instruction; exc_bd  in  1  committing instruction sits in a delay slot.
REQ-010 bad_vaddr  in  32  faulting address; bad_vaddr_we  in  1  capture strobe, honoured only together with exc.
REQ-011 eret  in  1  return strobe; int_req  out  1  flush/redirect request; epc_out  out  32  current EPC.

Function
REQ-012 Registers: BadVAddr(8), Count(9), Compare(11), SR(12), Cause(13), EPC(14), PrID(15); any other ra reads 0.
REQ-013 SR fields: IM[15:8], EXL[1], IE[0]; all other SR bits read back as written.
REQ-014 Cause fields: BD[31], IP[15:8], ExcCode[6:2]; other bits read 0.
REQ-015 IP[8+2+i] = registered hwint[i] for i < NUM_HWINT, sampled every cycle (1-cycle latency); IP[9:8] are software bits; unused IP bits read 0.
REQ-016 Interrupt accepted when IE=1, EXL=0 and |(IM & IP) using current registered values.
REQ-017 int_req = accepted_interrupt | exc, combinational, same cycle.
REQ-018 On int_req: EPC <= exc_bd ? exc_pc-4 : exc_pc; BD <= exc_bd; EXL <= 1.
REQ-019 ExcCode <= 0 when an interrupt is accepted; else exc_code; an interrupt has priority over a simultaneous exc.
REQ-020 BadVAddr <= bad_vaddr only when exc=1, no interrupt accepted and bad_vaddr_we=1.
REQ-021 eret with int_req=0: EXL <= 0, BD <= 0; eret with int_req=1 is ignored.
REQ-022 mtc0 writes SR, EPC, Count, Compare fully and Cause only at IP[9:8]; writes to BadVAddr, PrID and unmapped indices are dropped.
REQ-023 An mtc0 in a cycle with int_req=1 or eret=1 is dropped entirely.
REQ-024 epc_out = EPC register value (no bypass of same-cycle updates).
REQ-025 Priority per cycle: reset > int_req update > eret > mtc0.

Reset
REQ-026 On reset: SR = 32'h0000FF11, Cause = 0, EPC = 0, BadVAddr = 0, Count = 0, Compare = 32'hFFFFFFFF, timer pending = 0, registered hwint = 0.
REQ-027 Reset asserted mid-interrupt drops the pending update; int_req is 0 during the reset cycle; PrID always reads PRID_VAL.

Configuration
REQ-028 Macro CP0_EXT_TIMER_EN compiles in the timer.
REQ-029 With CP0_EXT_TIMER_EN: Count increments by 1 every cycle, wrapping 32'hFFFFFFFF -> 0; mtc0 Count loads wdata in place of the increment.
REQ-030 With CP0_EXT_TIMER_EN: Count == Compare sets a sticky timer pending bit, ORed into IP[15] (shared with hwint[5] if present).
REQ-031 With CP0_EXT_TIMER_EN: mtc0 Compare clears timer pending in the same edge; a match in that cycle is lost.
REQ-032 Without CP0_EXT_TIMER_EN: Count and Compare read 0, writes to them are dropped, IP[15] comes from hwint[5] only.

Verification
REQ-033 Reset, read 12/13/14/15 -> 0x0000FF11, 0, 0, PRID_VAL.
REQ-034 hwint[0]=1 at cycle 10, exc_pc=0x3010, exc_bd=0 -> int_req=1 at cycle 11, then EPC=0x3010, ExcCode=0, EXL=1, int_req=0 from cycle 12.
REQ-035 exc=1, exc_code=4, exc_bd=1, exc_pc=0x3008, bad_vaddr=0x1001, bad_vaddr_we=1 -> EPC=0x3004, BD=1, ExcCode=4, BadVAddr=0x1001.
REQ-036 hwint[2]=1 with exc=1, exc_code=10 in the same cycle -> ExcCode=0, EPC from exc_pc; eret next cycle -> EXL=0, BD=0.
REQ-037 mtc0 SR=0 with hwint[0]=1 -> no int_req; then mtc0 EPC=0x4000 with eret=1 in the same cycle -> EPC unchanged.
REQ-038 (TIMER_EN) Compare=20, Count=0 at cycle 0 -> Count==20 at cycle 20, int_req next cycle; mtc0 Compare clears IP[15].
